// File: rtl/flex_stp_deser_if.sv
// flex_stp_deser_if - serial sample / completed-word bundle for flex_stp_deser.
//
// Ports (by modport):
//   master : drives clear, shift_enable, wide_mode, serial_in, word_ready.
//            Observes shift_out, bit_count, word_out, word_valid, overrun.
//   slave  : the deserializer. It is the mirror image of master.
//
// WORD_BITS and NUM_LANES must match the parameters of the attached deserializer.
interface flex_stp_deser_if #(
  parameter int WORD_BITS = 8,
  parameter int NUM_LANES = 4
);
  localparam int CW = $clog2(WORD_BITS + 1);

  logic                 clear;
  logic                 shift_enable;
  logic                 wide_mode;
  logic [NUM_LANES-1:0] serial_in;
  logic                 word_ready;
  logic [WORD_BITS-1:0] shift_out;
  logic [CW-1:0]        bit_count;
  logic [WORD_BITS-1:0] word_out;
  logic                 word_valid;
  logic                 overrun;

  modport master (
    output clear, shift_enable, wide_mode, serial_in, word_ready,
    input  shift_out, bit_count, word_out, word_valid, overrun
  );

  modport slave (
    input  clear, shift_enable, wide_mode, serial_in, word_ready,
    output shift_out, bit_count, word_out, word_valid, overrun
  );
endinterface

// File: rtl/flex_stp_deser.sv
// flex_stp_deser - serial-to-parallel deserializer with word framing.
// It takes 1 bit or NUM_LANES bits per enabled clock (SD 1-bit / 4-bit bus) and packs them
// into WORD_BITS-wide words. Each finished word goes out through a one-deep valid/ready
// holding register.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : flex_stp_deser_if.slave
//          clear         synchronous abort, same effect as rst
//          shift_enable  sample serial_in this cycle
//          wide_mode     1 = NUM_LANES bits per enable, 0 = serial_in[0] only
//          serial_in     serial lanes, lane 0 least significant
//          word_ready    consumer accepts word_out this cycle
//          shift_out     live shift register
//          bit_count     bits collected in the current word
//          word_out      completed word holding register
//          word_valid    word_out holds an unconsumed word
//          overrun       sticky: a completed word was dropped
module flex_stp_deser #(
  parameter int WORD_BITS = 8,
  parameter int NUM_LANES = 4,
  parameter int SHIFT_MSB = 1
) (
  input  logic clk,
  input  logic rst,
  flex_stp_deser_if.slave bus
);
  localparam int CW = $clog2(WORD_BITS + 1);

  logic [WORD_BITS-1:0] shift_q, word_q, shift_nxt;
  logic [CW-1:0]        count_q, step, count_sum;
  logic                 mode_wide_q, valid_q, overrun_q;
  logic                 use_wide, complete;

  // The mode comes from the wide_mode pin only on the first beat of a word.
  // Every later beat uses the latched copy, so toggling the pin mid-word has no effect.
  always_comb begin
    use_wide  = (count_q == '0) ? bus.wide_mode : mode_wide_q;
    step      = use_wide ? CW'(NUM_LANES) : CW'(1);
    count_sum = count_q + step;
    complete  = bus.shift_enable && (count_sum == CW'(WORD_BITS));
  end

  // Shifting by the full step also covers NUM_LANES == WORD_BITS without an empty slice.
  always_comb begin
    shift_nxt = shift_q;
    if (SHIFT_MSB != 0) begin
      if (use_wide) shift_nxt = (shift_q << NUM_LANES) | WORD_BITS'(bus.serial_in);
      else          shift_nxt = (shift_q << 1) | WORD_BITS'(bus.serial_in[0]);
    end else begin
      if (use_wide) shift_nxt = (shift_q >> NUM_LANES) |
                                (WORD_BITS'(bus.serial_in) << (WORD_BITS - NUM_LANES));
      else          shift_nxt = (shift_q >> 1) |
                                (WORD_BITS'(bus.serial_in[0]) << (WORD_BITS - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '1;
      word_q      <= '1;
      count_q     <= '0;
      mode_wide_q <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (bus.clear) begin
      shift_q     <= '1;
      word_q      <= '1;
      count_q     <= '0;
      mode_wide_q <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (bus.shift_enable) begin
        shift_q <= shift_nxt;
        count_q <= complete ? '0 : count_sum;
        if (count_q == '0) mode_wide_q <= bus.wide_mode;
      end
      // A completing word can use the holder if the holder is empty or is being drained on this edge.
      if (complete && (!valid_q || bus.word_ready)) begin
        word_q  <= shift_nxt;
        valid_q <= 1'b1;
      end else if (complete) begin
        overrun_q <= 1'b1;
      end else if (valid_q && bus.word_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.shift_out  = shift_q;
  assign bus.bit_count  = count_q;
  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.overrun    = overrun_q;
endmodule
